// File: rtl/phy_tx_word_sched.sv
// Round-robin word scheduler feeding the PHY TX byte path: takes one 32-bit word
// per 4-cycle slot from a granted source and emits it MSB byte first on clk_4f.
module phy_tx_word_sched #(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = 2,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    reset_L,
    input  logic [NUM_SRC-1:0]      src_valid,
    input  logic [32*NUM_SRC-1:0]   src_data,
    input  logic [NUM_SRC-1:0]      src_en,
    output logic [NUM_SRC-1:0]      src_ready,
    output logic [7:0]              byte_out,
    output logic                    byte_valid,
    output logic [SRC_W-1:0]        byte_src,
    output logic                    word_start,
    output logic [CNT_W-1:0]        words_sent
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [SRC_W-1:0] LAST_GRANT_INIT = SRC_W'(NUM_SRC - 1);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [31:0]        shadow_r;
    logic [1:0]         cnt_r;
    logic [SRC_W-1:0]   last_grant_r;
    logic [SRC_W-1:0]   src_id_r;
    logic [CNT_W-1:0]   words_sent_r;
    logic [NUM_SRC-1:0] eligible_s;
    logic [SRC_W-1:0]   winner_s;
    logic               found_s;
    logic               accept_win_s;
    logic               take_s;

    assign eligible_s   = src_valid & src_en;
    assign accept_win_s = (state_r == IDLE) || (cnt_r == 2'd3);
    assign take_s       = accept_win_s & found_s;

    // Round-robin search starting one past the last granted source
    always_comb begin
        int idx_v;
        found_s  = 1'b0;
        winner_s = {SRC_W{1'b0}};
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx_v = (int'(last_grant_r) + k) % NUM_SRC;
            if (!found_s && eligible_s[idx_v]) begin
                found_s  = 1'b1;
                winner_s = SRC_W'(idx_v);
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Grant pulse, forced low whenever reset is asserted
    always_comb begin
        src_ready = {NUM_SRC{1'b0}};
        if (reset_L && take_s) begin
            src_ready[winner_s] = 1'b1;
        end else begin
            src_ready = {NUM_SRC{1'b0}};
        end
    end

    // Next-state logic: a slot either rolls into a new word or goes idle
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (take_s) begin
                    state_nxt_s = SEND;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SEND: begin
                if (cnt_r != 2'd3) begin
                    state_nxt_s = SEND;
                end else if (take_s) begin
                    state_nxt_s = SEND;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Word capture, byte index, grant pointer and saturating word counter
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            shadow_r     <= 32'h0000_0000;
            cnt_r        <= 2'd0;
            last_grant_r <= LAST_GRANT_INIT;
            src_id_r     <= {SRC_W{1'b0}};
            words_sent_r <= {CNT_W{1'b0}};
        end else if (take_s) begin
            shadow_r     <= src_data[32*int'(winner_s) +: 32];
            cnt_r        <= 2'd0;
            last_grant_r <= winner_s;
            src_id_r     <= winner_s;
            if (!(&words_sent_r)) begin
                words_sent_r <= words_sent_r + CNT_W'(1);
            end
        end else if (accept_win_s) begin
            cnt_r <= 2'd0;
        end else begin
            cnt_r <= cnt_r + 2'd1;
        end
    end

    // Byte mux, MSB first
    always_comb begin
        byte_out = 8'h00;
        if (state_r == SEND) begin
            case (cnt_r)
                2'd0:    byte_out = shadow_r[31:24];
                2'd1:    byte_out = shadow_r[23:16];
                2'd2:    byte_out = shadow_r[15:8];
                2'd3:    byte_out = shadow_r[7:0];
                default: byte_out = 8'h00;
            endcase
        end else begin
            byte_out = 8'h00;
        end
    end

    assign byte_valid = (state_r == SEND);
    assign byte_src   = src_id_r;
    assign word_start = (state_r == SEND) && (cnt_r == 2'd0);
    assign words_sent = words_sent_r;

endmodule

// File: tb/tb_phy_tx_word_sched.sv
// Bench for phy_tx_word_sched: directed scenarios plus random traffic, compared
// cycle by cycle against a byte-queue model of the scheduler.
module tb_phy_tx_word_sched;

    localparam int NS = 4;
    localparam int SW = 2;
    localparam int CW = 4;

    logic              clk;
    logic              reset_L;
    logic [NS-1:0]     src_valid;
    logic [32*NS-1:0]  src_data;
    logic [NS-1:0]     src_en;
    logic [NS-1:0]     src_ready;
    logic [7:0]        byte_out;
    logic              byte_valid;
    logic [SW-1:0]     byte_src;
    logic              word_start;
    logic [CW-1:0]     words_sent;

    int n_checks;
    int n_fail;

    // Model state: bytes still to be shown, their owner and first-byte flag
    logic [7:0] qb[$];
    int         qs[$];
    bit         qst[$];
    int         m_lg;
    int         m_src;
    int         m_words;
    bit         m_known;

    phy_tx_word_sched #(.NUM_SRC(NS), .SRC_W(SW), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset_L    (reset_L),
        .src_valid  (src_valid),
        .src_data   (src_data),
        .src_en     (src_en),
        .src_ready  (src_ready),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_src   (byte_src),
        .word_start (word_start),
        .words_sent (words_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // One clock: apply inputs, check outputs mid-cycle, advance the model
    task automatic step(input logic [NS-1:0] v, input logic [NS-1:0] e, input logic rl);
        int win;
        int idx;
        logic [NS-1:0] exp_rdy;
        logic [31:0]   w;
        src_valid = v;
        src_en    = e;
        reset_L   = rl;
        @(negedge clk);
        win     = -1;
        exp_rdy = '0;
        if (rl && qb.size() <= 1) begin
            for (int k = 1; k <= NS; k++) begin
                idx = (m_lg + k) % NS;
                if (win < 0 && v[idx] && e[idx]) win = idx;
            end
        end
        if (win >= 0) exp_rdy[win] = 1'b1;
        chk("src_ready", 32'(src_ready), 32'(exp_rdy));
        if (m_known) begin
            if (qb.size() > 0) begin
                chk("byte_valid", 32'(byte_valid), 32'd1);
                chk("byte_out",   32'(byte_out),   32'(qb[0]));
                chk("byte_src",   32'(byte_src),   32'(qs[0]));
                chk("word_start", 32'(word_start), 32'(qst[0]));
            end else begin
                chk("byte_valid", 32'(byte_valid), 32'd0);
                chk("byte_out",   32'(byte_out),   32'd0);
                chk("byte_src",   32'(byte_src),   32'(m_src));
                chk("word_start", 32'(word_start), 32'd0);
            end
            chk("words_sent", 32'(words_sent), 32'(m_words));
        end
        if (!rl) begin
            qb.delete(); qs.delete(); qst.delete();
            m_lg = NS - 1; m_src = 0; m_words = 0; m_known = 1'b1;
        end else begin
            if (qb.size() > 0) begin
                void'(qb.pop_front()); void'(qs.pop_front()); void'(qst.pop_front());
            end
            if (win >= 0) begin
                w = src_data[32*win +: 32];
                for (int b = 3; b >= 0; b--) begin
                    qb.push_back(w[8*b +: 8]);
                    qs.push_back(win);
                    qst.push_back(b == 3);
                end
                m_lg = win; m_src = win;
                if (m_words < (1 << CW) - 1) m_words++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        m_lg = NS - 1; m_src = 0; m_words = 0; m_known = 1'b0;
        src_valid = '0; src_en = '1; src_data = '0; reset_L = 1'b0;
        #1;
        step(4'b0000, 4'b1111, 1'b0);
        step(4'b0000, 4'b1111, 1'b0);

        // Single word from source 1
        src_data[63:32] = 32'hA1B2C3D4;
        step(4'b0010, 4'b1111, 1'b1);
        for (int i = 0; i < 5; i++) step(4'b0000, 4'b1111, 1'b1);
        chk("t1_words", 32'(words_sent), 32'd1);

        // All sources continuously valid
        for (int i = 0; i < NS; i++) src_data[32*i +: 32] = 32'(i * 16 + i);
        for (int i = 0; i < 20; i++) step(4'b1111, 4'b1111, 1'b1);

        // Source 2 disabled
        for (int i = 0; i < 24; i++) step(4'b1111, 4'b1011, 1'b1);
        for (int i = 0; i < 5; i++) step(4'b0000, 4'b1111, 1'b1);

        // Reset in the middle of a word
        src_data[31:0] = 32'h11223344;
        step(4'b0001, 4'b1111, 1'b1);
        step(4'b0000, 4'b1111, 1'b1);
        step(4'b0000, 4'b1111, 1'b0);
        chk("t4_valid", 32'(byte_valid), 32'd0);
        chk("t4_words", 32'(words_sent), 32'd0);
        step(4'b0001, 4'b1111, 1'b1);

        // Late request from source 3 landing on the final byte
        for (int i = 0; i < 3; i++) step(4'b0000, 4'b1111, 1'b1);
        step(4'b0001, 4'b1111, 1'b1);
        src_data[127:96] = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) step(4'b0000, 4'b1111, 1'b1);
        step(4'b1000, 4'b1111, 1'b1);
        for (int i = 0; i < 5; i++) step(4'b0000, 4'b1111, 1'b1);

        // Counter saturation
        for (int i = 0; i < 80; i++) step(4'b1111, 4'b1111, 1'b1);
        chk("t6_sat", 32'(words_sent), 32'd15);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            for (int s = 0; s < NS; s++) src_data[32*s +: 32] = $urandom;
            step(4'($urandom),
                 ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1111,
                 ($urandom_range(0, 49) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
